seq_restoring_divider: RTL



---
 rtl/seq_restoring_divider.sv | 129 ++++++++++++
 1 files changed

// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider
//   Multi-cycle unsigned restoring divider. It produces one quotient bit per
//   clock and uses a start/busy/done handshake.
//
// Ports
//   clk          system clock (rising edge)
//   rst_n        asynchronous active-low reset
//   start        request a division; ignored while busy
//   dividend     unsigned dividend, captured on the accepting edge
//   divisor      unsigned divisor, captured on the accepting edge
//   busy         high while iterating (CALC)
//   done         one-cycle pulse while results are freshly valid (FIN)
//   quotient     result, held until the next result is produced
//   remainder    result, held until the next result is produced
//   div_by_zero  set together with done when the captured divisor was 0
module seq_restoring_divider #(
  parameter int unsigned WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIN
  } state_t;

  state_t state, state_nx;

  logic [WIDTH:0]   prem;       // partial remainder
  logic [WIDTH-1:0] shreg;      // dividend shifting out, quotient shifting in
  logic [WIDTH-1:0] dvs;        // captured divisor
  logic [CW-1:0]    cnt;        // iterations still to perform

  logic [WIDTH:0]   prem_sh;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   prem_nx;
  logic [WIDTH-1:0] shreg_nx;
  logic             accept;
  logic             last;

  // One restoring step: shift {prem, shreg} left, try subtracting the divisor,
  // keep the difference only when it did not go negative.
  always_comb begin
    prem_sh  = {prem[WIDTH-1:0], shreg[WIDTH-1]};
    trial    = prem_sh - {1'b0, dvs};
    shreg_nx = {shreg[WIDTH-2:0], ~trial[WIDTH]};
    prem_nx  = trial[WIDTH] ? prem_sh : trial;
  end

  // FIN accepts a new request exactly like IDLE, giving back-to-back operation.
  assign accept = start && (state != CALC);
  assign last   = (cnt == CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nx = (divisor == '0) ? FIN : CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (last) state_nx = FIN;
      end
      FIN: begin
        done = 1'b1;
        if (start) state_nx = (divisor == '0) ? FIN : CALC;
        else       state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Results only move on the edge entering FIN, so the previous result stays
  // visible for the whole CALC phase of a nonzero-divisor operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prem        <= '0;
      shreg       <= '0;
      dvs         <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      dvs <= divisor;
      if (divisor == '0) begin
        prem        <= '0;
        shreg       <= '0;
        cnt         <= '0;
        quotient    <= '1;
        remainder   <= dividend;
        div_by_zero <= 1'b1;
      end else begin
        prem  <= '0;
        shreg <= dividend;
        cnt   <= CW'(WIDTH);
      end
    end else if (state == CALC) begin
      prem  <= prem_nx;
      shreg <= shreg_nx;
      cnt   <= cnt - CW'(1);
      if (last) begin
        quotient    <= shreg_nx;
        remainder   <= prem_nx[WIDTH-1:0];
        div_by_zero <= 1'b0;
      end
    end
  end

endmodule
